// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM encodings and defaults for the pipeline controller.
package pipe_ctrl_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t DIV_WAIT = 2'd1;
  localparam state_t REPLAY = 2'd2;
  localparam int DefAddrWidth = 32;
  localparam logic [DefAddrWidth-1:0] ZeroWord = '0;
endpackage

// File: rtl/pipe_ctrl_timer.sv
// pipe_ctrl_timer: divide-wait timeout counter and saturating stall counter.
module pipe_ctrl_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int TimeoutCycles = 64,
  parameter int CntWidth = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                wait_i,
  output logic                tmo_o,
  output logic [CntWidth-1:0] stall_cnt_o
);
  localparam int TW = $clog2(TimeoutCycles) + 1;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [CntWidth-1:0] stall_q, stall_d;
  always_comb begin
    tmo_d = clr_i ? '0 : wait_i ? tmo_q + 1'b1 : tmo_q;
    stall_d = wait_i ? stall_q + {{(CntWidth-1){1'b0}}, ~&stall_q} : stall_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
      stall_q <= '0;
    end else begin
      tmo_q <= tmo_d;
      stall_q <= stall_d;
    end
  end
  assign tmo_o = tmo_q == TW'(TimeoutCycles - 1);
  assign stall_cnt_o = stall_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard/redirect controller with multi-cycle divide stall and replay.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int AddrWidth = DefAddrWidth,
  parameter int TimeoutCycles = 64,
  parameter int CntWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 jump_i,
  input  logic [AddrWidth-1:0] jump_addr_i,
  input  logic                 load_use_i,
  input  logic [AddrWidth-1:0] id_pc_i,
  input  logic                 div_start_i,
  input  logic                 div_done_i,
  input  logic [AddrWidth-1:0] ex_pc_i,
  output logic                 jump_flag_o,
  output logic [AddrWidth-1:0] jump_addr_o,
  output logic                 pc_hold_o,
  output logic                 if_id_flush_o,
  output logic                 id_ex_flush_o,
  output logic                 err_o,
  output logic [CntWidth-1:0]  stall_cnt_o
);
  state_t state_q, state_d;
  logic [AddrWidth-1:0] resume_q, resume_d;
  logic err_q, err_d;
  logic idle, waiting, replay, start, load, tmo;
  pipe_ctrl_timer #(.TimeoutCycles(TimeoutCycles), .CntWidth(CntWidth)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (start),
    .wait_i     (waiting),
    .tmo_o      (tmo),
    .stall_cnt_o(stall_cnt_o)
  );
  always_comb begin
    idle = state_q == IDLE;
    waiting = state_q == DIV_WAIT;
    replay = state_q == REPLAY;
    start = idle & ~jump_i & div_start_i;
    load = idle & ~jump_i & ~div_start_i & load_use_i;
    jump_flag_o = replay | (idle & jump_i) | load;
    jump_addr_o = replay ? resume_q : (idle & jump_i) ? jump_addr_i : load ? id_pc_i : '0;
    pc_hold_o = waiting | start;
    if_id_flush_o = ~idle | jump_i | div_start_i | load_use_i;
    id_ex_flush_o = if_id_flush_o;
    state_d = (start | (waiting & ~div_done_i & ~tmo)) ? DIV_WAIT : waiting ? REPLAY : IDLE;
    resume_d = start ? ex_pc_i + AddrWidth'(4) : resume_q;
    err_d = err_q | (waiting & tmo & ~div_done_i);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      resume_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      resume_q <= resume_d;
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic jump_i, load_use_i, div_start_i, div_done_i;
  logic [31:0] jump_addr_i, id_pc_i, ex_pc_i, jump_addr_o;
  logic jump_flag_o, pc_hold_o, if_id_flush_o, id_ex_flush_o, err_o;
  logic [15:0] stall_cnt_o;
  int tests = 0, failed = 0;
  always #5 clk = ~clk;
  pipe_ctrl dut (
    .clk(clk), .rst(rst), .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .load_use_i(load_use_i), .id_pc_i(id_pc_i), .div_start_i(div_start_i),
    .div_done_i(div_done_i), .ex_pc_i(ex_pc_i), .jump_flag_o(jump_flag_o),
    .jump_addr_o(jump_addr_o), .pc_hold_o(pc_hold_o), .if_id_flush_o(if_id_flush_o),
    .id_ex_flush_o(id_ex_flush_o), .err_o(err_o), .stall_cnt_o(stall_cnt_o)
  );
  wire [3:0] ctl = {jump_flag_o, pc_hold_o, if_id_flush_o, id_ex_flush_o};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    {jump_i, load_use_i, div_start_i, div_done_i} = '0;
    jump_addr_i = '0;
    id_pc_i = '0;
    ex_pc_i = '0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_in();
    rst = 1'b0;
    tick();
    #1;
    tests++;
    if ({ctl, jump_addr_o, err_o, stall_cnt_o} !== '0) begin
      failed++;
      $display("FAIL reset_idle: ctl=%b addr=%h err=%b stall=%0d, want all 0", ctl, jump_addr_o, err_o, stall_cnt_o);
    end
    jump_i = 1'b1;
    jump_addr_i = 32'h55;
    #1;
    tests++;
    if ({ctl, jump_addr_o} !== {4'b1011, 32'h55}) begin
      failed++;
      $display("FAIL reset_comb_jump: ctl=%b addr=%h, want 1011 00000055", ctl, jump_addr_o);
    end
    do_reset();
  endtask

  task automatic test_jump();
    do_reset();
    jump_i = 1'b1;
    jump_addr_i = 32'h100;
    #1;
    tests++;
    if ({ctl, jump_addr_o} !== {4'b1011, 32'h100}) begin
      failed++;
      $display("FAIL jump: ctl=%b addr=%h, want 1011 00000100", ctl, jump_addr_o);
    end
    tick();
    clear_in();
    #1;
    tests++;
    if ({ctl, jump_addr_o} !== '0) begin
      failed++;
      $display("FAIL jump_after: ctl=%b addr=%h, want 0000 0", ctl, jump_addr_o);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    load_use_i = 1'b1;
    id_pc_i = 32'h40;
    #1;
    tests++;
    if ({ctl, jump_addr_o} !== {4'b1011, 32'h40}) begin
      failed++;
      $display("FAIL load_use: ctl=%b addr=%h, want 1011 00000040", ctl, jump_addr_o);
    end
    tick();
    clear_in();
    #1;
    tests++;
    if ({ctl, jump_addr_o} !== '0) begin
      failed++;
      $display("FAIL load_use_after: ctl=%b addr=%h, want 0000 0", ctl, jump_addr_o);
    end
  endtask

  task automatic test_div();
    int holds = 0;
    do_reset();
    div_start_i = 1'b1;
    div_done_i = 1'b1;
    ex_pc_i = 32'h80;
    #1;
    tests++;
    if ({ctl, jump_addr_o} !== {4'b0111, 32'h0}) begin
      failed++;
      $display("FAIL div_start: ctl=%b addr=%h, want 0111 0", ctl, jump_addr_o);
    end
    holds += pc_hold_o;
    for (int i = 1; i <= 5; i++) begin
      tick();
      clear_in();
      jump_i = 1'b1;
      load_use_i = 1'b1;
      div_start_i = 1'b1;
      jump_addr_i = 32'hDEAD;
      div_done_i = (i == 5);
      #1;
      holds += pc_hold_o;
      tests++;
      if (ctl !== 4'b0111) begin
        failed++;
        $display("FAIL div_wait_%0d: ctl=%b, want 0111", i, ctl);
      end
    end
    tick();
    clear_in();
    #1;
    tests++;
    if ({ctl, jump_addr_o, stall_cnt_o, err_o, holds} !== {4'b1011, 32'h84, 16'd5, 1'b0, 32'd6}) begin
      failed++;
      $display("FAIL div_replay: ctl=%b addr=%h stall=%0d err=%b holds=%0d, want 1011 00000084 5 0 6", ctl, jump_addr_o, stall_cnt_o, err_o, holds);
    end
    tick();
    #1;
    tests++;
    if ({ctl, jump_addr_o} !== '0) begin
      failed++;
      $display("FAIL div_after: ctl=%b addr=%h, want 0000 0", ctl, jump_addr_o);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    div_start_i = 1'b1;
    ex_pc_i = 32'hFFFF_FFFC;
    tick();
    clear_in();
    forever begin
      #1;
      if (!pc_hold_o || n >= 200) break;
      if (n == 63) begin
        tests++;
        if (err_o !== 1'b0) begin
          failed++;
          $display("FAIL tmo_err_early: err=%b, want 0", err_o);
        end
      end
      n++;
      tick();
    end
    tests++;
    if ({n, ctl, jump_addr_o, err_o, stall_cnt_o} !== {32'd64, 4'b1011, 32'h0, 1'b1, 16'd64}) begin
      failed++;
      $display("FAIL tmo_replay: waits=%0d ctl=%b addr=%h err=%b stall=%0d, want 64 1011 0 1 64", n, ctl, jump_addr_o, err_o, stall_cnt_o);
    end
    tick();
    #1;
    tests++;
    if ({ctl, err_o} !== {4'b0000, 1'b1}) begin
      failed++;
      $display("FAIL tmo_sticky: ctl=%b err=%b, want 0000 1", ctl, err_o);
    end
  endtask

  task automatic test_priority();
    do_reset();
    {jump_i, div_start_i, load_use_i} = 3'b111;
    jump_addr_i = 32'h200;
    id_pc_i = 32'h40;
    ex_pc_i = 32'h80;
    #1;
    tests++;
    if ({ctl, jump_addr_o} !== {4'b1011, 32'h200}) begin
      failed++;
      $display("FAIL prio_same: ctl=%b addr=%h, want 1011 00000200", ctl, jump_addr_o);
    end
    tick();
    clear_in();
    #1;
    tests++;
    if ({ctl, stall_cnt_o} !== '0) begin
      failed++;
      $display("FAIL prio_idle: ctl=%b stall=%0d, want 0000 0", ctl, stall_cnt_o);
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    div_start_i = 1'b1;
    ex_pc_i = 32'h80;
    tick();
    clear_in();
    tick();
    tick();
    #1;
    tests++;
    if ({ctl, stall_cnt_o} !== {4'b0111, 16'd2}) begin
      failed++;
      $display("FAIL abort_wait: ctl=%b stall=%0d, want 0111 2", ctl, stall_cnt_o);
    end
    rst = 1'b0;
    #1;
    tests++;
    if ({ctl, jump_addr_o, stall_cnt_o, err_o} !== '0) begin
      failed++;
      $display("FAIL abort_reset: ctl=%b addr=%h stall=%0d err=%b, want all 0", ctl, jump_addr_o, stall_cnt_o, err_o);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({ctl, jump_addr_o} !== '0) begin
        failed++;
        $display("FAIL abort_after_%0d: ctl=%b addr=%h, want 0000 0", i, ctl, jump_addr_o);
      end
    end
  endtask

  initial begin
    clear_in();
    test_reset();
    test_jump();
    test_load_use();
    test_div();
    test_timeout();
    test_priority();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
